// File: rtl/mem_access_stage.sv
// Memory stage: steers EX/MEM operands onto the data-memory req/ack bus and
// registers the MEM/WB writeback bundle, flagging misaligned and timed-out accesses.
module mem_access_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    output logic                  stall,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [3:0]            dm_be,
    output logic [31:0]           dm_wdata,
    input  logic [31:0]           dm_rdata,
    input  logic                  dm_ack,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  misalign_exc,
    output logic                  bus_err
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam int              CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO = CW'(TIMEOUT);

    logic [0:0]    state;
    logic [CW-1:0] count;

    logic        mem_op;
    logic        is_store;
    logic        is_load;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic [31:0] addr32;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        mem_op   = in_valid & (in_mem_read | in_mem_write);
        is_store = in_mem_write;
        is_load  = in_mem_read & ~in_mem_write;
        addr32   = 32'(in_addr);

        case (in_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = in_addr[0];
            2'b10:   misaligned = |in_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = in_wdata;
        case (in_size)
            2'b00: begin
                lane_be    = 4'b0001 << in_addr[1:0];
                lane_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << in_addr[1:0];
                lane_wdata = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dm_rdata[{in_addr[1:0], 3'b000} +: 8];
        ld_half = dm_rdata[{in_addr[1], 4'b0000} +: 16];
        case (in_size)
            2'b00:   load_data = in_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = in_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = dm_rdata;
        endcase
    end

    // Gated by rst so every output, stall included, reads 0 while reset is held.
    always_comb begin
        if (state == S_IDLE) begin
            stall = rst & mem_op & ~misaligned;
        end else begin
            stall = rst & ~dm_ack & (count < TMO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            count        <= '0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_be        <= '0;
            dm_wdata     <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op && misaligned) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= in_rd;
                        wb_data      <= addr32;
                        misalign_exc <= 1'b1;
                    end else if (mem_op) begin
                        state    <= S_WAIT;
                        count    <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        dm_be    <= lane_be;
                        dm_wdata <= lane_wdata;
                    end else begin
                        wb_valid     <= in_valid;
                        wb_reg_write <= in_valid & in_reg_write;
                        wb_rd        <= in_rd;
                        wb_data      <= addr32;
                    end
                end
                default: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (dm_ack) begin
                        state        <= S_IDLE;
                        dm_req       <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= in_reg_write & is_load;
                        wb_rd        <= in_rd;
                        wb_data      <= is_load ? load_data : addr32;
                    end else if (count >= TMO) begin
                        state    <= S_IDLE;
                        dm_req   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= in_rd;
                        wb_data  <= addr32;
                        bus_err  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
